// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on the input and output
// channels. Base ops finish in one cycle. When SEQ_ALU_MULDIV_EN is defined,
// codes 1010-1111 run an iterative multiply/divide through BUSY/FIX.
//
// state | meaning
// IDLE  | no result held, ready for an op
// BUSY  | iterative mul/div, one step per cycle
// FIX   | sign correction, load result and flags
// HOLD  | result valid, waiting for out_ready
module seq_alu #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [3:0]       control,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag,
  output logic             c_flag
);

  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, HOLD} state_t;
  state_t state;

  logic            accept;
  logic [XLEN:0]   add_full;
  logic [XLEN:0]   sub_full;
  logic            add_v;
  logic            sub_v;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] base_res;
  logic            base_v;
  logic            base_c;

  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  // a - b is formed as a + ~b + 1 so the carry out reads directly as no-borrow
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
  assign add_v    = (a[XLEN-1] == b[XLEN-1]) && (add_full[XLEN-1] != a[XLEN-1]);
  assign sub_v    = (a[XLEN-1] != b[XLEN-1]) && (sub_full[XLEN-1] != a[XLEN-1]);
  assign shamt    = b[SH_W-1:0];

  // Single-cycle result and flags for the base op codes
  always_comb begin
    base_res = '0;
    base_v   = 1'b0;
    base_c   = 1'b0;
    case (control)
      4'b0000: base_res = a & b;
      4'b0001: base_res = a | b;
      4'b0010: begin
        base_res = add_full[XLEN-1:0];
        base_v   = add_v;
        base_c   = add_full[XLEN];
      end
      4'b0011: base_res = a >> shamt;
      4'b0100: base_res = a ^ b;
      4'b0101: base_res = a << shamt;
      4'b0110: begin
        base_res = sub_full[XLEN-1:0];
        base_v   = sub_v;
        base_c   = sub_full[XLEN];
      end
      4'b0111: base_res = $unsigned($signed(a) >>> shamt);
      4'b1000: base_res = {{(XLEN-1){1'b0}}, sub_full[XLEN-1] ^ sub_v};
      4'b1001: base_res = {{(XLEN-1){1'b0}}, ~sub_full[XLEN]};
      default: base_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // acc: product high half / partial remainder
  // lo:  multiplier / dividend shifting into quotient
  // opnd: multiplicand / divisor magnitude
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [SH_W-1:0] cnt;
  logic [2:0]      mop;
  logic            neg_q;
  logic            neg_r;
  logic            is_mop;
  logic            sgn;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   r_sh;
  logic            div_ge;
  logic [XLEN-1:0] fix_res;

  assign is_mop  = control[3] & (control[2] | control[1]);
  assign sgn     = control[2] & ~control[0];
  assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign r_sh    = {acc, lo[XLEN-1]};
  assign div_ge  = r_sh >= {1'b0, opnd};

  // Sign correction of the finished unsigned mul/div result
  always_comb begin
    fix_res = '0;
    case (mop)
      3'b010:         fix_res = lo;
      3'b011:         fix_res = acc;
      3'b100, 3'b101: fix_res = neg_q ? -lo : lo;
      3'b110, 3'b111: fix_res = neg_r ? -acc : acc;
      default:        fix_res = '0;
    endcase
  end
`endif

  // Control FSM with registered result, flags, tag and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      z_flag    <= 1'b0;
      n_flag    <= 1'b0;
      v_flag    <= 1'b0;
      c_flag    <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      acc       <= '0;
      lo        <= '0;
      opnd      <= '0;
      cnt       <= '0;
      mop       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (accept) begin
      out_tag <= in_tag;
`ifdef SEQ_ALU_MULDIV_EN
      if (is_mop) begin
        if (control[2]) begin
          lo   <= (sgn && a[XLEN-1]) ? -a : a;
          opnd <= (sgn && b[XLEN-1]) ? -b : b;
        end else begin
          lo   <= b;
          opnd <= a;
        end
        acc       <= '0;
        cnt       <= SH_W'(XLEN - 1);
        mop       <= control[2:0];
        // a zero divisor keeps the all-ones quotient unnegated
        neg_q     <= sgn & (a[XLEN-1] ^ b[XLEN-1]) & (b != '0);
        neg_r     <= sgn & a[XLEN-1];
        out_valid <= 1'b0;
        state     <= BUSY;
      end else
`endif
      begin
        result    <= base_res;
        z_flag    <= (base_res == '0);
        n_flag    <= base_res[XLEN-1];
        v_flag    <= base_v;
        c_flag    <= base_c;
        out_valid <= 1'b1;
        state     <= HOLD;
      end
    end else begin
      case (state)
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef SEQ_ALU_MULDIV_EN
        BUSY: begin
          if (mop[2]) begin
            acc <= div_ge ? (r_sh[XLEN-1:0] - opnd) : r_sh[XLEN-1:0];
            lo  <= {lo[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_sum[XLEN:1];
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end
          cnt <= cnt - SH_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          result    <= fix_res;
          z_flag    <= (fix_res == '0);
          n_flag    <= fix_res[XLEN-1];
          v_flag    <= 1'b0;
          c_flag    <= 1'b0;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (XLEN=64). Mul/div checks follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [3:0]       control;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             z_flag, n_flag, v_flag, c_flag;

  seq_alu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .z_flag(z_flag), .n_flag(n_flag),
    .v_flag(v_flag), .c_flag(c_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]       ctl;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    logic [3:0]       f;  // {z, n, v, c}
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MAX  = {1'b0, {(XLEN-1){1'b1}}};

  // One op through the handshake; checks latency, result, z/n and tag
  task automatic run_op(input string nm, input logic [3:0] ctl, input logic [XLEN-1:0] av,
                        input logic [XLEN-1:0] bv, input logic [TAG_W-1:0] tg,
                        input logic [XLEN-1:0] exp, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    control = ctl; a = av; b = bv; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    chk({nm, " in_ready"}, XLEN'(in_ready), XLEN'(1));
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (lat == 1 && exp_lat > 1) chk({nm, " busy in_ready"}, XLEN'(in_ready), XLEN'(0));
      if (out_valid) got = 1'b1;
    end
    chk({nm, " latency"}, XLEN'(lat), XLEN'(exp_lat));
    chk({nm, " result"}, result, exp);
    chk({nm, " z"}, XLEN'(z_flag), XLEN'(exp == '0));
    chk({nm, " n"}, XLEN'(n_flag), XLEN'(exp[XLEN-1]));
    chk({nm, " tag"}, XLEN'(out_tag), XLEN'(tg));
  endtask

  initial begin
    bit stale;
    vecs[0]  = '{4'b0010, MAX, 64'd1, 5'd3, MIN, 4'b0110};
    vecs[1]  = '{4'b0110, 64'd5, 64'd5, 5'd4, 64'd0, 4'b1001};
    vecs[2]  = '{4'b0111, MIN, 64'h43, 5'd5, 64'hF000_0000_0000_0000, 4'b0100};
    vecs[3]  = '{4'b0101, 64'd1, 64'd63, 5'd6, MIN, 4'b0100};
    vecs[4]  = '{4'b1001, 64'd1, ONES, 5'd7, 64'd1, 4'b0000};
    vecs[5]  = '{4'b1000, 64'd1, ONES, 5'd8, 64'd0, 4'b1000};
    vecs[6]  = '{4'b0000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd9,
                 64'hF000_F000_F000_F000, 4'b0100};
    vecs[7]  = '{4'b0001, 64'h0F, 64'hF0, 5'd10, 64'hFF, 4'b0000};
    vecs[8]  = '{4'b0100, 64'h1234, 64'h1234, 5'd11, 64'd0, 4'b1000};
    vecs[9]  = '{4'b0011, MIN, 64'h104, 5'd12, 64'h0800_0000_0000_0000, 4'b0000};
    vecs[10] = '{4'b0010, ONES, 64'd1, 5'd13, 64'd0, 4'b1001};
    vecs[11] = '{4'b0110, 64'd0, 64'd1, 5'd14, ONES, 4'b0100};
    vecs[12] = '{4'b0110, MIN, 64'd1, 5'd15, MAX, 4'b0011};
    vecs[13] = '{4'b1000, ONES, 64'd1, 5'd16, 64'd1, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; control = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", XLEN'(out_valid), XLEN'(0));
    chk("reset result", result, '0);
    chk("reset tag", XLEN'(out_tag), XLEN'(0));
    chk("reset flags", XLEN'({z_flag, n_flag, v_flag, c_flag}), XLEN'(0));
    chk("reset in_ready", XLEN'(in_ready), XLEN'(1));

    // back-to-back stream: one op per cycle, each result seen one cycle later
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        chk($sformatf("vec%0d valid", i - 1), XLEN'(out_valid), XLEN'(1));
        chk($sformatf("vec%0d result", i - 1), result, vecs[i-1].res);
        chk($sformatf("vec%0d flags", i - 1), XLEN'({z_flag, n_flag, v_flag, c_flag}),
            XLEN'(vecs[i-1].f));
        chk($sformatf("vec%0d tag", i - 1), XLEN'(out_tag), XLEN'(vecs[i-1].tag));
      end
      if (i < NV) begin
        chk($sformatf("vec%0d in_ready", i), XLEN'(in_ready), XLEN'(1));
        control = vecs[i].ctl; a = vecs[i].a; b = vecs[i].b; in_tag = vecs[i].tag;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end

    // backpressure: AND result held for 4 cycles, pending ADD must not be lost
    out_ready = 1'b0;
    control = 4'b0000; a = 64'hFF; b = 64'h0F; in_tag = 5'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    control = 4'b0010; a = 64'd2; b = 64'd3; in_tag = 5'd21;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("bp%0d valid", k), XLEN'(out_valid), XLEN'(1));
      chk($sformatf("bp%0d result", k), result, 64'h0F);
      chk($sformatf("bp%0d tag", k), XLEN'(out_tag), XLEN'(20));
      chk($sformatf("bp%0d in_ready", k), XLEN'(in_ready), XLEN'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", XLEN'(in_ready), XLEN'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp add valid", XLEN'(out_valid), XLEN'(1));
    chk("bp add result", result, 64'd5);
    chk("bp add tag", XLEN'(out_tag), XLEN'(21));
    @(posedge clk);
    @(negedge clk);
    chk("bp drained", XLEN'(out_valid), XLEN'(0));

`ifdef SEQ_ALU_MULDIV_EN
    run_op("mul", 4'b1010, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, XLEN + 2);
    run_op("mulhu", 4'b1011, ONES, ONES, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, XLEN + 2);
    run_op("mul zero", 4'b1010, 64'd0, 64'd123, 5'd3, 64'd0, XLEN + 2);
    run_op("div", 4'b1100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, XLEN + 2);
    run_op("rem", 4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, ONES, XLEN + 2);
    run_op("divu0", 4'b1101, 64'd5, 64'd0, 5'd6, ONES, XLEN + 2);
    run_op("remu0", 4'b1111, 64'd5, 64'd0, 5'd7, 64'd5, XLEN + 2);
    run_op("div ovf", 4'b1100, MIN, ONES, 5'd8, MIN, XLEN + 2);
    run_op("rem ovf", 4'b1110, MIN, ONES, 5'd9, 64'd0, XLEN + 2);
    run_op("divu", 4'b1101, 64'd100, 64'd7, 5'd10, 64'd14, XLEN + 2);
    run_op("remu", 4'b1111, 64'd100, 64'd7, 5'd11, 64'd2, XLEN + 2);
`else
    run_op("undef div", 4'b1100, 64'd100, 64'd7, 5'd12, 64'd0, 1);
    run_op("undef mul", 4'b1010, 64'd3, 64'd7, 5'd13, 64'd0, 1);
    run_op("undef remu", 4'b1111, 64'd5, 64'd0, 5'd14, 64'd0, 1);
`endif

    // reset in the middle of an in-flight op; nothing may come out afterwards
    @(negedge clk);
    control = 4'b1100; a = 64'd100; b = 64'd7; in_tag = 5'd30; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst out_valid", XLEN'(out_valid), XLEN'(0));
    chk("mid rst in_ready", XLEN'(in_ready), XLEN'(1));
    chk("mid rst result", result, '0);
    out_ready = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("mid rst no stale result", XLEN'(stale), XLEN'(0));

    run_op("post rst add", 4'b0010, 64'd40, 64'd2, 5'd31, 64'd42, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the combinational 64-bit ALU.
- Accepts one operation per handshake on a valid/ready input channel and returns the result, flags and a passthrough tag on a valid/ready output channel.
- Base ops (AND/OR/ADD/SUB/shifts/XOR/SLT/SLTU) complete in 1 cycle.
- Optional iterative multiply/divide (RV M subset) takes multiple cycles.
- Sits between the decode/issue stage and writeback of the pipelined core.

Parameters:
- XLEN, 64: operand/result width. Power of two, ≥ 8. Shift amount is b[$clog2(XLEN)-1:0].
- TAG_W, 5: width of the opaque tag (destination register index) carried with each op.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2/imm)
- control  in  4  op code
- in_tag  in  TAG_W  tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result when out_valid && out_ready
- result  out  XLEN  result
- out_tag  out  TAG_W  tag of the result
- z_flag  out  1  result == 0
- n_flag  out  1  result[XLEN-1]
- v_flag  out  1  signed overflow (ADD/SUB only, else 0)
- c_flag  out  1  carry out (ADD; SUB = no-borrow; else 0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port rst.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SRL, 0100 XOR, 0101 SLL, 0110 SUB, 0111 SRA, 1000 SLT, 1001 SLTU.
  - With the feature: 1010 MUL (low XLEN), 1011 MULHU (high XLEN, unsigned), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
  - Undefined/disabled codes: result 0, z=1, n=v=c=0, 1-cycle latency.
- Arithmetic:
  - All arithmetic is modulo 2^XLEN.
  - SLT/SLTU return 1 or 0 zero-extended.
  - SLT uses N xor V of a-b; SLTU uses !carry of a+~b+1.
  - Shifts use only the low $clog2(XLEN) bits of b.
- Reset: out_valid=0, result=0, out_tag=0, all flags 0. State goes to IDLE. Any in-flight op is discarded, with no output produced for it.
- FSM states: IDLE, BUSY, FIX, HOLD.
  - IDLE, accepted base op: the result register loads on that edge and the FSM goes to HOLD. out_valid is high the cycle after acceptance (latency 1).
  - IDLE, accepted M op: operands are captured as magnitudes (signed ops take abs), sign bits are recorded, counter=XLEN-1, go to BUSY.
  - BUSY: one shift-add (MUL/MULHU) or restoring subtract-shift (DIV/REM) step per cycle. When counter==0, go to FIX.
  - FIX: apply sign correction (quotient negated if signs differ; remainder takes dividend sign). Load result and flags, go to HOLD.
  - M-op latency is fixed: out_valid asserts XLEN+2 cycles after the accept edge, regardless of operand values.
  - HOLD: out_valid=1. result, flags and out_tag are stable until out_valid && out_ready. Then go to IDLE, or directly accept the next op (see in_ready).
- in_ready = (state==IDLE) || (state==HOLD && out_ready), i.e. base ops can stream back-to-back at 1 op/cycle. in_ready is 0 in BUSY and FIX.
- Changes on in_* while in_ready=0 are ignored.
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a. Same fixed latency.
- Signed overflow: DIV of MIN by -1 gives MIN; REM gives 0.
- The tag is captured at acceptance and presented unchanged with the result.

Optional Feature:
SEQ_ALU_MULDIV_EN.
- Defined: codes 1010–1111 execute as above through BUSY/FIX.
- Undefined: BUSY/FIX logic is not built. Codes 1010–1111 behave as undefined codes (result 0, z=1, latency 1), and in_ready never drops for multi-cycle work.

Test Plan:
1. Reset, then stream with XLEN=64 and out_ready=1:
   - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → result 0x8000_0000_0000_0000, v=1, n=1, c=0.
   - SUB 5-5 → result 0, z=1, c=1.
   - Both are back-to-back with 1-cycle latency, and tags 3 and 4 are returned in order.
2. Shifts:
   - SRA a=0x8000_0000_0000_0000, b=0x43 (amt 3) → 0xF000_0000_0000_0000.
   - SLL 1 by b=63 → 0x8000_0000_0000_0000.
   - SLTU 1 < 0xFFFF_FFFF_FFFF_FFFF → 1; SLT of the same operands → 0.
3. Backpressure: hold out_ready=0 for 4 cycles after an AND result. result/out_tag stay stable, in_ready=0, and a new in_valid op is not lost: it is accepted on the cycle out_ready rises.
4. MUL_EN: MUL -3 × 7 → 0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 66 cycles after accept. MULHU 0xFFFF_FFFF_FFFF_FFFF² → 0xFFFF_FFFF_FFFF_FFFE.
5. MUL_EN divide:
   - DIV -7/2 → -3; REM -7/2 → -1.
   - DIVU 5/0 → all ones; REMU 5/0 → 5.
   - DIV MIN/-1 → MIN, REM → 0.
6. Assert rst in the middle of a DIV (cycle 20 of BUSY). Next cycle: out_valid=0, in_ready=1, no stale result ever appears. Without MULDIV_EN, code 1100 → result 0, z=1 after 1 cycle.
